// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer on refclk: pulses pll_rst, qualifies extlock, releases sys_rst after stable lock.
// Optional retry limit (FAULT state) enabled by defining PLL_RETRY_LIMIT_EN.
module pll_lock_ctrl #(
  parameter int RST_CYCLES   = 24,
  parameter int LOCK_STABLE  = 240,
  parameter int LOCK_TIMEOUT = 24000,
  parameter int LOSS_FILTER  = 4,
  parameter int SYSRST_DELAY = 16,
  parameter int MAX_RETRY    = 3
) (
  input  logic       refclk,
  input  logic       reset,
  input  logic       extlock,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       locked,
  output logic [1:0] state,
  output logic [3:0] retry_cnt,
  output logic       pll_fault
);

  typedef enum logic [1:0] {
    RST_HOLD  = 2'd0,
    WAIT_LOCK = 2'd1,
    LOCKED    = 2'd2,
    FAULT     = 2'd3
  } state_e;

`ifdef PLL_RETRY_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);
  localparam logic [15:0] STABLE_N  = 16'(LOCK_STABLE);
  localparam logic [15:0] TIMEOUT_N = 16'(LOCK_TIMEOUT);
  localparam logic [15:0] LOSS_N    = 16'(LOSS_FILTER);
  localparam logic [15:0] SYSDLY_N  = 16'(SYSRST_DELAY);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;   // hold count / timeout count / sys_rst delay, by state
  logic [15:0] run_q, run_d;   // stable-lock run in WAIT_LOCK, loss run in LOCKED
  logic [3:0]  retry_q, retry_d, retry_inc;
  logic        sync1_q, sync2_q, lock_s;
  logic        pll_rst_q, sys_rst_q, locked_q;

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= extlock;
      sync2_q <= sync1_q;
    end
  end

  assign lock_s    = sync2_q;
  assign retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    retry_d = retry_q;
    case (state_q)
      RST_HOLD: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          run_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT_LOCK: begin
        cnt_d = cnt_q + 16'd1;
        run_d = lock_s ? run_q + 16'd1 : '0;
        // relock beats lock completion, which beats timeout
        if (relock_req) begin
          state_d = RST_HOLD;
          cnt_d   = '0;
          run_d   = '0;
        end else if (run_d == STABLE_N) begin
          state_d = LOCKED;
          retry_d = '0;
          cnt_d   = '0;
          run_d   = '0;
        end else if (cnt_d == TIMEOUT_N) begin
          retry_d = retry_inc;
          state_d = (LIMIT_EN && retry_inc == RETRY_MAX) ? FAULT : RST_HOLD;
          cnt_d   = '0;
          run_d   = '0;
        end
      end
      LOCKED: begin
        cnt_d = (cnt_q == SYSDLY_N) ? cnt_q : cnt_q + 16'd1;
        run_d = lock_s ? '0 : run_q + 16'd1;
        if (relock_req || run_d == LOSS_N) begin
          state_d = RST_HOLD;
          cnt_d   = '0;
          run_d   = '0;
        end
      end
      default: begin
        if (relock_req) begin
          state_d = RST_HOLD;
          retry_d = '0;
          cnt_d   = '0;
          run_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      state_q   <= RST_HOLD;
      cnt_q     <= '0;
      run_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      retry_q   <= retry_d;
      // outputs decoded from next state so they move on the same edge as state
      pll_rst_q <= (state_d == RST_HOLD) || (state_d == FAULT);
      sys_rst_q <= !((state_d == LOCKED) && (cnt_d >= SYSDLY_N));
      locked_q  <= (state_d == LOCKED);
    end
  end

`ifdef PLL_RETRY_LIMIT_EN
  logic fault_q;
  always_ff @(posedge refclk or posedge reset) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= (state_d == FAULT);
  end
  assign pll_fault = fault_q;
`else
  assign pll_fault = 1'b0;
`endif

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign locked    = locked_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: directed scenarios plus randomized extlock/relock traffic against a cycle model.
module tb_pll_lock_ctrl;
  localparam int RC = 4, LS = 8, LT = 50, LF = 3, SD = 5, MR = 2;
`ifdef PLL_RETRY_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic       refclk = 1'b0;
  logic       reset, extlock, relock_req;
  logic       pll_rst, sys_rst, locked, pll_fault;
  logic [1:0] state;
  logic [3:0] retry_cnt;

  always #5 refclk = ~refclk;

  pll_lock_ctrl #(
    .RST_CYCLES(RC), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT),
    .LOSS_FILTER(LF), .SYSRST_DELAY(SD), .MAX_RETRY(MR)
  ) dut (
    .refclk(refclk), .reset(reset), .extlock(extlock), .relock_req(relock_req),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .locked(locked), .state(state),
    .retry_cnt(retry_cnt), .pll_fault(pll_fault)
  );

  int n_cmp = 0, n_err = 0;

  // Reference model: phase (0 hold,1 wait,2 locked,3 fault), cycles spent in phase,
  // current run of synchronized lock (ones in wait, zeros in locked), retries.
  int m_ph, m_age, m_run, m_retry;
  bit m_pipe[$];

  task automatic m_reset();
    m_ph = 0; m_age = 0; m_run = 0; m_retry = 0;
    m_pipe.delete(); m_pipe.push_back(1'b0); m_pipe.push_back(1'b0);
  endtask

  task automatic m_go(input int p);
    m_ph = p; m_age = 0; m_run = 0;
  endtask

  task automatic m_edge();
    bit ls;
    ls = m_pipe.pop_front();
    m_pipe.push_back(extlock);
    m_age++;
    case (m_ph)
      0: if (m_age == RC) m_go(1);
      1: begin
        m_run = ls ? m_run + 1 : 0;
        if (relock_req) m_go(0);
        else if (m_run == LS) begin m_retry = 0; m_go(2); end
        else if (m_age == LT) begin
          m_retry = (m_retry < 15) ? m_retry + 1 : 15;
          m_go((LIM && m_retry == MR) ? 3 : 0);
        end
      end
      2: begin
        m_run = ls ? 0 : m_run + 1;
        if (relock_req || m_run == LF) m_go(0);
      end
      default: if (relock_req) begin m_retry = 0; m_go(0); end
    endcase
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("state",   int'(state),     m_ph);
    chk("pll_rst", int'(pll_rst),   int'(m_ph == 0 || m_ph == 3));
    chk("sys_rst", int'(sys_rst),   int'(!(m_ph == 2 && m_age >= SD)));
    chk("locked",  int'(locked),    int'(m_ph == 2));
    chk("retry",   int'(retry_cnt), m_retry);
    chk("fault",   int'(pll_fault), int'(LIM && m_ph == 3));
  endtask

  task automatic step();
    @(posedge refclk);
    if (reset) m_reset(); else m_edge();
    @(negedge refclk);
    check_all();
  endtask

  task automatic pulse_relock();
    relock_req = 1'b1; step(); relock_req = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; extlock = 1'b1; relock_req = 1'b0;
    m_reset();
    repeat (2) @(negedge refclk);
    check_all();

    // power-up with extlock already high
    reset = 1'b0;
    n = 0;
    while (pll_rst && n < 20) begin step(); n++; end
    chk("pwr_pll_rst_cycles", n, RC);
    n = 0;
    while (!locked && n < 100) begin step(); n++; end
    chk("pwr_locked", int'(locked), 1);
    n = 0;
    while (sys_rst && n < 50) begin step(); n++; end
    chk("pwr_sysrst_delay", n, SD);
    repeat (4) step();

    // short glitch is filtered
    extlock = 1'b0; repeat (2) step(); extlock = 1'b1;
    repeat (6) step();
    chk("glitch2_state", int'(state), 2);
    chk("glitch2_sysrst", int'(sys_rst), 0);

    // three-cycle drop is a loss; keep extlock low into the next WAIT_LOCK
    extlock = 1'b0;
    n = 0;
    while (state != 2'd0 && n < 20) begin step(); n++; end
    chk("loss_state", int'(state), 0);
    chk("loss_sysrst", int'(sys_rst), 1);
    chk("loss_pllrst", int'(pll_rst), 1);
    chk("loss_retry", int'(retry_cnt), 0);

    // lock latency from WAIT_LOCK entry with extlock rising at entry: 2 sync + LS
    n = 0;
    while (state != 2'd1 && n < 20) begin step(); n++; end
    extlock = 1'b1;
    n = 0;
    while (!locked && n < 100) begin step(); n++; end
    chk("lock_latency", n, 2 + LS);
    repeat (SD + 1) step();

    // timeouts: each RST_HOLD+WAIT_LOCK round costs RC+LT cycles
    extlock = 1'b0;
    n = 0;
    while (state != 2'd0 && n < 20) begin step(); n++; end
    for (int k = 1; k <= (LIM ? MR : 4); k++) begin
      n = 0;
      while (int'(retry_cnt) != k && n < 200) begin step(); n++; end
      chk("timeout_period", n, RC + LT);
    end
    if (LIM) begin
      chk("fault_state", int'(state), 3);
      chk("fault_flag", int'(pll_fault), 1);
      chk("fault_retry", int'(retry_cnt), MR);
      chk("fault_pllrst", int'(pll_rst), 1);
      repeat (10) step();
      pulse_relock();
      chk("fault_exit_state", int'(state), 0);
      chk("fault_exit_retry", int'(retry_cnt), 0);
      chk("fault_exit_flag", int'(pll_fault), 0);
    end else begin
      chk("nofault_state", int'(state != 2'd3), 1);
      chk("nofault_flag", int'(pll_fault), 0);
    end
    extlock = 1'b1;
    n = 0;
    while (!locked && n < 200) begin step(); n++; end
    chk("relock_locked", int'(locked), 1);
    chk("relock_retry", int'(retry_cnt), 0);
    repeat (SD + 1) step();

    // relock_req on the cycle the stable count completes wins
    extlock = 1'b0;
    pulse_relock();
    n = 0;
    while (state != 2'd1 && n < 20) begin step(); n++; end
    extlock = 1'b1;
    repeat (2 + LS - 1) step();
    pulse_relock();
    chk("prio_state", int'(state), 0);
    chk("prio_locked", int'(locked), 0);

    // async reset in WAIT_LOCK with retry_cnt=1
    extlock = 1'b0;
    n = 0;
    while (int'(retry_cnt) != 1 && n < 300) begin step(); n++; end
    n = 0;
    while (state != 2'd1 && n < 20) begin step(); n++; end
    chk("ar_pre_retry", int'(retry_cnt), 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_state", int'(state), 0);
    chk("ar_pllrst", int'(pll_rst), 1);
    chk("ar_sysrst", int'(sys_rst), 1);
    chk("ar_locked", int'(locked), 0);
    chk("ar_retry", int'(retry_cnt), 0);
    chk("ar_fault", int'(pll_fault), 0);
    m_reset();
    step();
    reset = 1'b0;

    // randomized traffic
    for (int seg = 0; seg < 300; seg++) begin
      int len;
      extlock = ($urandom_range(0, 3) != 0);
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(40, 90) : $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        relock_req = ($urandom_range(0, 63) == 0);
        step();
        relock_req = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
